// File: rtl/csr_unit_pkg.sv
// Shared types for the CSR execution unit: op codes, FSM encoding and latched-op records.
// Widths are fixed by the core: 6-bit physical/ROB tags, 14-bit CSR numbers, 32-bit data.
package csr_unit_pkg;

  localparam int unsigned PTAG_W = 6;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned CSR_AW = 14;
  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] CSRRD_CONF = 4'd0;
  localparam logic [3:0] CSRWR_CONF = 4'd1;
  localparam logic [3:0] CSRXG_CONF = 4'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // Fields captured from the issue queue at acceptance.
  typedef struct packed {
    logic [ROB_W-1:0]  tag_rob;
    logic [3:0]        conf;
    logic [PTAG_W-1:0] pj;
    logic [PTAG_W-1:0] pd_old;
    logic [PTAG_W-1:0] pd;
    logic [CSR_AW-1:0] csr_addr;
    logic              reg_wr;
    logic              csr_wr;
  } op_t;

  // Results sampled in EXEC and held until the grant cycle.
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] new_val;
    logic              do_write;
  } exec_t;

  function automatic logic conf_writes_csr(input logic [3:0] conf);
    return (conf == CSRWR_CONF) || (conf == CSRXG_CONF);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// New-CSR-value computation: csrwr replaces, csrxchg merges rd into old under mask rj.
// Purely combinational; no backpressure.
module csr_alu
  import csr_unit_pkg::*;
(
  input  logic [3:0]        conf,
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rj_val,
  output logic [DATA_W-1:0] new_val,
  output logic              do_write
);

  always_comb begin
    new_val  = old_val;
    do_write = 1'b0;
    case (conf)
      CSRWR_CONF: begin
        new_val  = rd_val;
        do_write = conf_writes_csr(conf);
      end
      CSRXG_CONF: begin
        new_val  = (rd_val & rj_val) | (old_val & ~rj_val);
        do_write = conf_writes_csr(conf);
      end
      default: begin
        new_val  = old_val;
        do_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Executes one csrrd/csrwr/csrxchg at a time: IDLE->READ->EXEC->WB, result on CDB channel 4 at t+3.
// WB holds cdb_req until granted; CSR write and CDB broadcast fire together, flush cancels both.
module csr_unit
  import csr_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic        ready_awake,
  input  logic [5:0]  tag_rob_awake,
  input  logic [3:0]  Conf_awake,
  input  logic [5:0]  Pj_awake,
  input  logic [5:0]  Pd_old_awake,
  input  logic [5:0]  Pd_awake,
  input  logic [13:0] csr_addr_awake,
  input  logic        RegWr_awake,
  input  logic        csrWr_awake,

  output logic        busy,

  output logic [5:0]  prf_raddr_j,
  output logic [5:0]  prf_raddr_d,
  input  logic [31:0] prf_rdata_j,
  input  logic [31:0] prf_rdata_d,

  output logic [13:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_we,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wdata,

  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic        ready_cdb,
  output logic        RegWr_cdb,
  output logic [5:0]  Pd_cdb,
  output logic [5:0]  tag_rob_cdb,
  output logic [31:0] data_cdb
);

  state_t state;
  state_t state_nxt;
  op_t    op;
  exec_t  ex;

  logic [31:0] alu_new;
  logic        alu_we;
  logic        accept;
  logic        fire;

  assign accept = (state == IDLE) && ready_awake && !flush;
  assign fire   = (state == WB) && cdb_grant && !flush;

  csr_alu u_alu (
    .conf     (op.conf),
    .old_val  (csr_rdata),
    .rd_val   (prf_rdata_d),
    .rj_val   (prf_rdata_j),
    .new_val  (alu_new),
    .do_write (alu_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ready_awake) state_nxt = READ;
        READ:    state_nxt = EXEC;
        EXEC:    state_nxt = WB;
        WB:      if (cdb_grant) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    prf_raddr_j = '0;
    prf_raddr_d = '0;
    csr_raddr   = '0;
    cdb_req     = 1'b0;
    ready_cdb   = 1'b0;
    RegWr_cdb   = 1'b0;
    Pd_cdb      = '0;
    tag_rob_cdb = '0;
    data_cdb    = '0;
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    case (state)
      READ: begin
        prf_raddr_j = op.pj;
        prf_raddr_d = op.pd_old;
        csr_raddr   = op.csr_addr;
      end
      WB: begin
        cdb_req = 1'b1;
        if (fire) begin
          ready_cdb   = 1'b1;
          RegWr_cdb   = op.reg_wr;
          Pd_cdb      = op.pd;
          tag_rob_cdb = op.tag_rob;
          data_cdb    = ex.res;
          csr_we      = op.csr_wr && ex.do_write;
          csr_waddr   = op.csr_addr;
          csr_wdata   = ex.new_val;
        end
      end
      default: begin
        cdb_req = 1'b0;
      end
    endcase
  end

  // Operand capture at issue, result capture one cycle after the reads are launched.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      op <= '0;
      ex <= '0;
    end else begin
      if (accept) begin
        op <= '{tag_rob:  tag_rob_awake,
                conf:     Conf_awake,
                pj:       Pj_awake,
                pd_old:   Pd_old_awake,
                pd:       Pd_awake,
                csr_addr: csr_addr_awake,
                reg_wr:   RegWr_awake,
                csr_wr:   csrWr_awake};
      end
      if (state == EXEC) begin
        ex.res      <= csr_rdata;
        ex.new_val  <= alu_new;
        ex.do_write <= alu_we;
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with a registered-read PRF/CSR-file model and hand-computed results.
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ready_awake;
  logic [5:0]  tag_rob_awake, Pj_awake, Pd_old_awake, Pd_awake;
  logic [3:0]  Conf_awake;
  logic [13:0] csr_addr_awake;
  logic        RegWr_awake, csrWr_awake;
  logic        busy;
  logic [5:0]  prf_raddr_j, prf_raddr_d;
  logic [31:0] prf_rdata_j, prf_rdata_d;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_we, cdb_req, cdb_grant, ready_cdb, RegWr_cdb;
  logic [5:0]  Pd_cdb, tag_rob_cdb;
  logic [31:0] data_cdb;

  logic [31:0] prf [0:63];
  logic [31:0] csr_mem [0:16383];
  logic        poke_csr, poke_prf;
  logic [13:0] poke_addr;
  logic [31:0] poke_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ready_awake(ready_awake), .tag_rob_awake(tag_rob_awake), .Conf_awake(Conf_awake),
    .Pj_awake(Pj_awake), .Pd_old_awake(Pd_old_awake), .Pd_awake(Pd_awake),
    .csr_addr_awake(csr_addr_awake), .RegWr_awake(RegWr_awake), .csrWr_awake(csrWr_awake),
    .busy(busy),
    .prf_raddr_j(prf_raddr_j), .prf_raddr_d(prf_raddr_d),
    .prf_rdata_j(prf_rdata_j), .prf_rdata_d(prf_rdata_d),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .ready_cdb(ready_cdb),
    .RegWr_cdb(RegWr_cdb), .Pd_cdb(Pd_cdb), .tag_rob_cdb(tag_rob_cdb), .data_cdb(data_cdb)
  );

  // Register file and CSR file return data one cycle after the address.
  always @(posedge clk) begin
    prf_rdata_j <= prf[prf_raddr_j];
    prf_rdata_d <= prf[prf_raddr_d];
    csr_rdata   <= csr_mem[csr_raddr];
    if (csr_we)   csr_mem[csr_waddr] <= csr_wdata;
    if (poke_csr) csr_mem[poke_addr] <= poke_dat;
    if (poke_prf) prf[poke_addr[5:0]] <= poke_dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic is_csr, input logic [13:0] addr, input logic [31:0] dat);
    poke_csr  = is_csr;
    poke_prf  = !is_csr;
    poke_addr = addr;
    poke_dat  = dat;
    @(negedge clk);
    poke_csr = 1'b0;
    poke_prf = 1'b0;
  endtask

  // Drives one awake pulse at the current negedge; returns at the negedge of the READ cycle.
  task automatic issue(input logic [3:0] conf, input logic [5:0] pj, input logic [5:0] pd_old,
                       input logic [5:0] pd, input logic [13:0] addr, input logic regwr,
                       input logic csrwr, input logic [5:0] rob);
    Conf_awake     = conf;
    Pj_awake       = pj;
    Pd_old_awake   = pd_old;
    Pd_awake       = pd;
    csr_addr_awake = addr;
    RegWr_awake    = regwr;
    csrWr_awake    = csrwr;
    tag_rob_awake  = rob;
    ready_awake    = 1'b1;
    @(negedge clk);
    ready_awake = 1'b0;
  endtask

  // From the READ negedge with grant high: EXEC quiet, WB fires, then IDLE.
  task automatic expect_op(input string tag, input logic [31:0] data, input logic [5:0] pd,
                           input logic [5:0] rob, input logic regwr, input logic we,
                           input logic [13:0] waddr, input logic [31:0] wdata);
    @(negedge clk);
    check({tag, "_exec_rdy"}, 32'(ready_cdb), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_wb_rdy"}, 32'(ready_cdb), 32'd1);
    check({tag, "_wb_data"}, data_cdb, data);
    check({tag, "_wb_pd"}, 32'(Pd_cdb), 32'(pd));
    check({tag, "_wb_rob"}, 32'(tag_rob_cdb), 32'(rob));
    check({tag, "_wb_regwr"}, 32'(RegWr_cdb), 32'(regwr));
    check({tag, "_wb_we"}, 32'(csr_we), 32'(we));
    if (we) begin
      check({tag, "_wb_waddr"}, 32'(csr_waddr), 32'(waddr));
      check({tag, "_wb_wdata"}, csr_wdata, wdata);
    end
    @(negedge clk);
    check({tag, "_after_rdy"}, 32'(ready_cdb), 32'd0);
    check({tag, "_after_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ready_awake = 1'b0; cdb_grant = 1'b0;
    Conf_awake = '0; Pj_awake = '0; Pd_old_awake = '0; Pd_awake = '0;
    csr_addr_awake = '0; RegWr_awake = 1'b0; csrWr_awake = 1'b0; tag_rob_awake = '0;
    poke_csr = 1'b0; poke_prf = 1'b0; poke_addr = '0; poke_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(cdb_req), 32'd0);
    check("rst_rdy", 32'(ready_cdb), 32'd0);
    check("rst_we", 32'(csr_we), 32'd0);
    check("rst_raddr", 32'(csr_raddr), 32'd0);
    check("rst_data", data_cdb, 32'd0);

    // csrrd
    poke(1'b1, 14'h0006, 32'h0000_1234);
    poke(1'b0, 14'd7, 32'hDEAD_0000);
    cdb_grant = 1'b1;
    issue(CSRRD_CONF, 6'd3, 6'd7, 6'd5, 14'h0006, 1'b1, 1'b0, 6'd9);
    check("rd_read_busy", 32'(busy), 32'd1);
    check("rd_read_rj", 32'(prf_raddr_j), 32'd3);
    check("rd_read_rd", 32'(prf_raddr_d), 32'd7);
    check("rd_read_csr", 32'(csr_raddr), 32'h6);
    check("rd_read_req", 32'(cdb_req), 32'd0);
    expect_op("rd", 32'h0000_1234, 6'd5, 6'd9, 1'b1, 1'b0, 14'h0, 32'h0);

    // csrwr
    poke(1'b1, 14'h0010, 32'hAAAA_0000);
    poke(1'b0, 14'd7, 32'h0000_BEEF);
    issue(CSRWR_CONF, 6'd2, 6'd7, 6'd12, 14'h0010, 1'b1, 1'b1, 6'd10);
    expect_op("wr", 32'hAAAA_0000, 6'd12, 6'd10, 1'b1, 1'b1, 14'h0010, 32'h0000_BEEF);
    check("wr_committed", csr_mem[16], 32'h0000_BEEF);

    // csrwr with csrWr clear: broadcast only
    issue(CSRWR_CONF, 6'd2, 6'd7, 6'd13, 14'h0010, 1'b1, 1'b0, 6'd14);
    expect_op("wr_nowe", 32'h0000_BEEF, 6'd13, 6'd14, 1'b1, 1'b0, 14'h0, 32'h0);

    // csrxchg, RegWr=0 still pulses ready_cdb
    poke(1'b1, 14'h0020, 32'hFFFF_0000);
    poke(1'b0, 14'd8, 32'h1234_5678);
    poke(1'b0, 14'd3, 32'h0000_FFFF);
    issue(CSRXG_CONF, 6'd3, 6'd8, 6'd20, 14'h0020, 1'b0, 1'b1, 6'd11);
    expect_op("xg", 32'hFFFF_0000, 6'd20, 6'd11, 1'b0, 1'b1, 14'h0020, 32'hFFFF_5678);
    check("xg_committed", csr_mem[32], 32'hFFFF_5678);

    // unknown Conf never writes
    issue(4'd7, 6'd3, 6'd8, 6'd21, 14'h0020, 1'b1, 1'b1, 6'd12);
    expect_op("unk", 32'hFFFF_5678, 6'd21, 6'd12, 1'b1, 1'b0, 14'h0, 32'h0);

    // grant withheld five WB cycles
    cdb_grant = 1'b0;
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd6, 14'h0006, 1'b1, 1'b0, 6'd15);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_req", 32'(cdb_req), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_rdy", 32'(ready_cdb), 32'd0);
      @(negedge clk);
    end
    cdb_grant = 1'b1;
    #1;
    check("hold_grant_rdy", 32'(ready_cdb), 32'd1);
    check("hold_grant_data", data_cdb, 32'h0000_1234);
    check("hold_grant_rob", 32'(tag_rob_cdb), 32'd15);
    @(negedge clk);
    check("hold_after_rdy", 32'(ready_cdb), 32'd0);
    check("hold_after_busy", 32'(busy), 32'd0);
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd7, 14'h0010, 1'b1, 1'b0, 6'd16);
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_accept_csr", 32'(csr_raddr), 32'h10);
    expect_op("b2b", 32'h0000_BEEF, 6'd7, 6'd16, 1'b1, 1'b0, 14'h0, 32'h0);

    // flush in EXEC
    poke(1'b1, 14'h0030, 32'h0000_0055);
    issue(CSRWR_CONF, 6'd0, 6'd7, 6'd22, 14'h0030, 1'b1, 1'b1, 6'd17);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_exec_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("fl_exec_rdy", 32'(ready_cdb), 32'd0);
      check("fl_exec_we", 32'(csr_we), 32'd0);
      @(negedge clk);
    end
    check("fl_exec_mem", csr_mem[48], 32'h0000_0055);

    // flush coincident with grant
    issue(CSRWR_CONF, 6'd0, 6'd7, 6'd22, 14'h0030, 1'b1, 1'b1, 6'd18);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_wb_rdy", 32'(ready_cdb), 32'd0);
    check("fl_wb_we", 32'(csr_we), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_wb_busy", 32'(busy), 32'd0);
    check("fl_wb_mem", csr_mem[48], 32'h0000_0055);
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd33, 14'h0030, 1'b1, 1'b0, 6'd40);
    expect_op("post_fl", 32'h0000_0055, 6'd33, 6'd40, 1'b1, 1'b0, 14'h0, 32'h0);

    // flush together with ready_awake in IDLE
    flush = 1'b1;
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd34, 14'h0006, 1'b1, 1'b0, 6'd41);
    flush = 1'b0;
    check("fl_awake_busy", 32'(busy), 32'd0);
    check("fl_awake_raddr", 32'(csr_raddr), 32'd0);

    // rst in WB
    cdb_grant = 1'b0;
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd35, 14'h0006, 1'b1, 1'b0, 6'd42);
    @(negedge clk);
    @(negedge clk);
    check("rstwb_req_before", 32'(cdb_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwb_busy", 32'(busy), 32'd0);
    check("rstwb_req", 32'(cdb_req), 32'd0);
    check("rstwb_rdy", 32'(ready_cdb), 32'd0);
    check("rstwb_pd", 32'(Pd_cdb), 32'd0);
    cdb_grant = 1'b1;
    issue(CSRRD_CONF, 6'd0, 6'd0, 6'd36, 14'h0006, 1'b1, 1'b0, 6'd43);
    expect_op("post_rst", 32'h0000_1234, 6'd36, 6'd43, 1'b1, 1'b0, 14'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Executes one CSR-class instruction (csrrd / csrwr / csrxchg) at a time, taking its operands from the CSR issue queue's awake outputs. It reads the physical register file and the CSR file, computes the new CSR value and the destination result, and commits the CSR write. It then broadcasts on CDB channel 4; that broadcast is what re-enables issue in the CSR queue, so this unit is the consuming end of that interface.

## Interface
- Parameters: none. Widths are fixed by the core: physical tag 6, ROB tag 6, CSR address 14, data 32.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; abandons the in-flight op.
- ready_awake  in  1  issue strobe from the CSR queue, one-cycle pulse.
- tag_rob_awake  in  6  ROB tag.
- Conf_awake  in  4  operation code (`CSRRD_CONF` / `CSRWR_CONF` / `CSRXG_CONF`).
- Pj_awake  in  6  mask source tag; used by xchg only.
- Pd_old_awake  in  6  tag holding the rd source value.
- Pd_awake  in  6  destination physical tag.
- csr_addr_awake  in  14  CSR number.
- RegWr_awake  in  1  destination write enable.
- csrWr_awake  in  1  CSR write enable.
- busy  out  1  state != IDLE; feeds the CSR queue stall.
- prf_raddr_j, prf_raddr_d  out  6  PRF read addresses; data returns the following cycle.
- prf_rdata_j, prf_rdata_d  in  32  PRF read data.
- csr_raddr  out  14  CSR file read address; data returns the following cycle.
- csr_rdata  in  32  CSR read data.
- csr_we  out  1  CSR write strobe.
- csr_waddr  out  14  CSR write address.
- csr_wdata  out  32  CSR write data.
- cdb_req  out  1  request for CDB channel 4.
- cdb_grant  in  1  arbiter grant.
- ready_cdb  out  1  CDB valid.
- RegWr_cdb  out  1  CDB register-write flag.
- Pd_cdb  out  6  CDB destination tag.
- tag_rob_cdb  out  6  CDB ROB tag.
- data_cdb  out  32  CDB result data.

## Operation
- FSM states:
  - IDLE: on ready_awake, latch all awake fields and go to READ. ready_awake in any other state is ignored; the queue guarantees it never happens.
  - READ: drive prf_raddr_j=Pj, prf_raddr_d=Pd_old, csr_raddr=csr_addr. Go to EXEC.
  - EXEC: sample the read data into registers:
    - old = csr_rdata
    - res = old
    - new value: csrwr → new = rd; csrxchg → new = (rd & rj) | (old & ~rj); csrrd or unknown Conf → no write.
    - Go to WB.
  - WB: assert cdb_req. In the first cycle with cdb_grant=1:
    - ready_cdb=1, RegWr_cdb=latched RegWr, Pd_cdb, tag_rob_cdb, data_cdb=res.
    - csr_we = csrWr && Conf ∈ {WR, XG}, with csr_waddr=csr_addr and csr_wdata=new.
    - Next state IDLE.
- RegWr=0 still produces the ready_cdb pulse, with RegWr_cdb=0, so the queue unlocks.
- ready_cdb, csr_we and all CDB payload outputs are combinational from (state==WB && cdb_grant && !flush). They are 0 otherwise.
- The CSR write and the CDB broadcast always occur in the same cycle, or neither occurs.

## Timing
- Reset: state IDLE; all latched fields 0; every output 0.
- Awake pulse at cycle t:
  - READ at t+1, EXEC at t+2, WB from t+3.
  - With grant held high, ready_cdb and csr_we pulse at t+3.
  - Each additional cycle of grant withheld adds one cycle.
- ready_cdb is exactly one cycle wide per op.
- Back-to-back issue: the next ready_awake is accepted in the cycle after the grant cycle (IDLE). Minimum spacing between issues is 4 cycles.
- flush in any state: next state IDLE, latched fields cleared.
  - flush coinciding with grant suppresses ready_cdb and csr_we.
  - flush coinciding with ready_awake in IDLE does not accept the op.
- rst has priority over flush and over every other input.

## Structure
- `CSRRD_CONF`=4'd0, `CSRWR_CONF`=4'd1, `CSRXG_CONF`=4'd2 and the state encoding live in the shared defs.svh. `CSRXG_CONF` is the same constant the CSR queue already uses.
- One natural sub-module: csr_alu, purely combinational. It takes (Conf, old, rd, rj) and produces (new, do_write).

## Test plan
- csrrd: csr 0x0006 holds 0x1234; awake Conf=RD, Pd=5, RegWr=1, grant high → at t+3 ready_cdb=1, Pd_cdb=5, data_cdb=0x1234, csr_we=0.
- csrwr: csr=0xAAAA0000, rd=0x0000BEEF → data_cdb=0xAAAA0000; csr_we=1, csr_wdata=0x0000BEEF in the same cycle.
- csrxchg: old=0xFFFF0000, rd=0x12345678, rj=0x0000FFFF → csr_wdata=0xFFFF5678, data_cdb=0xFFFF0000.
- Grant withheld 5 cycles → cdb_req held, busy=1, no ready_cdb; a single pulse on the first grant; the following awake is accepted one cycle later.
- flush in EXEC, and separately flush coincident with grant → no csr_we, no ready_cdb; IDLE next cycle; a new op then completes normally.
- rst asserted in WB → all outputs 0 next cycle; a subsequent csrrd completes with t+3 latency.
